// File: rtl/pipe_pkg.sv
// Shared definitions for the memory stage of the 5-stage pipeline.
//   - bit positions of the control word (sign_out) consumed by the stage
//   - branch condition codes and flag bit positions ({N,Z,C,V})
//   - memory-access FSM state encoding
//   - cond_true(): evaluates a condition code against a flag vector
package pipe_pkg;

  // Control word bit positions
  localparam int MEM_READ   = 5;
  localparam int MEM_WRITE  = 6;
  localparam int MEM_TO_REG = 7;
  localparam int BRANCH_EN  = 8;
  localparam int REG_WRITE  = 9;
  localparam int SET_COND   = 10;

  // Flag bit positions inside the 4-bit {N,Z,C,V} vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Branch condition codes; every unlisted code never branches
  localparam logic [3:0] CC_NEVER  = 4'b0000;
  localparam logic [3:0] CC_ALWAYS = 4'b0001;
  localparam logic [3:0] CC_EQ     = 4'b0010;
  localparam logic [3:0] CC_NE     = 4'b0011;
  localparam logic [3:0] CC_LT     = 4'b0100;
  localparam logic [3:0] CC_GE     = 4'b0101;
  localparam logic [3:0] CC_CS     = 4'b0110;
  localparam logic [3:0] CC_CC     = 4'b0111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  function automatic logic cond_true(input logic [3:0] cc, input logic [3:0] flags);
    logic res;
    case (cc)
      CC_NEVER:  res = 1'b0;
      CC_ALWAYS: res = 1'b1;
      CC_EQ:     res = flags[FLAG_Z];
      CC_NE:     res = ~flags[FLAG_Z];
      CC_LT:     res = flags[FLAG_N] ^ flags[FLAG_V];
      CC_GE:     res = ~(flags[FLAG_N] ^ flags[FLAG_V]);
      CC_CS:     res = flags[FLAG_C];
      CC_CC:     res = ~flags[FLAG_C];
      default:   res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/data_ram.sv
// Single-port synchronous data RAM, 32-bit words.
//   clk   : rising-edge clock
//   we    : write enable, writes wdata to addr on the clock edge
//   addr  : word index
//   wdata : write data
//   rdata : registered read data of addr (read-before-write on a same-edge write)
// Contents are not reset.
module data_ram #(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the 5-stage pipeline.
// Takes the execute latch outputs, performs fixed-latency data-memory loads
// and stores (stalling upstream while an access is in flight), resolves
// conditional branches against a stored flag register and drives the memory
// latch towards writeback and execute forwarding.
//
// Ports:
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   alu_result     : ALU result, also byte address for loads/stores
//   write_out      : store data
//   rd_out         : destination register
//   sign_out       : control word (see pipe_pkg bit positions)
//   branch         : ALU flags {N,Z,C,V}
//   br_cond_out    : branch condition code
//   newPC          : branch target
//   data_out       : registered writeback data
//   mem_rd         : registered destination register
//   mem_signal     : registered register-write valid (0 on bubbles)
//   pc_src         : registered branch-taken (0 on bubbles)
//   branch_target  : registered copy of newPC
//   stall          : combinational, upstream latches hold while high
module mem_stage
  import pipe_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_out,
  input  logic [3:0]  rd_out,
  input  logic [10:0] sign_out,
  input  logic [3:0]  branch,
  input  logic [3:0]  br_cond_out,
  input  logic [31:0] newPC,
  output logic [31:0] data_out,
  output logic [3:0]  mem_rd,
  output logic        mem_signal,
  output logic        pc_src,
  output logic [31:0] branch_target,
  output logic        stall
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

  mem_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    flags_q;
  logic          stall_c;
  logic          load_edge;
  logic          mem_read, mem_write, mem_op;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_rdata;
  logic          taken_p0;
  logic          unused_bits;

  assign mem_read  = sign_out[MEM_READ];
  assign mem_write = sign_out[MEM_WRITE];
  assign mem_op    = mem_read | mem_write;

  // Low two address bits select a byte and are ignored; upper bits wrap.
  assign ram_addr = alu_result[AW+1:2];

  // Store commits only on the completion edge, so an access aborted by
  // reset never reaches the RAM.
  assign ram_we = mem_write & (state_q == ST_WAIT) & (cnt_q == '0);

  assign unused_bits = ^{sign_out[4:0], alu_result[31:AW+2], alu_result[1:0]};

  data_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (write_out),
    .rdata (ram_rdata)
  );

  // Access FSM: IDLE either completes a non-memory op or starts a wait;
  // WAIT counts down and completes the access when the counter hits zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_c   = 1'b0;
    load_edge = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op) begin
          stall_c = 1'b1;
          state_d = ST_WAIT;
          cnt_d   = CNT_INIT;
        end else begin
          load_edge = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - CW'(1);
        end else begin
          load_edge = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Gated by reset so stall drops the moment reset is asserted.
  assign stall = stall_c & rst_n;

  // Branch decision uses the flags as they stood before this edge's update.
  assign taken_p0 = sign_out[BRANCH_EN] & cond_true(br_cond_out, flags_q);

  // ---- memory latch boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      flags_q       <= '0;
      data_out      <= '0;
      mem_rd        <= '0;
      mem_signal    <= 1'b0;
      pc_src        <= 1'b0;
      branch_target <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load_edge) begin
        mem_rd        <= rd_out;
        mem_signal    <= sign_out[REG_WRITE];
        // RAM read data was captured on the previous edge; the address has
        // been held stable by the stall since the access started.
        data_out      <= sign_out[MEM_TO_REG] ? ram_rdata : alu_result;
        pc_src        <= taken_p0;
        branch_target <= newPC;
        if (sign_out[SET_COND]) begin
          flags_q <= branch;
        end
      end else begin
        mem_signal <= 1'b0;
        pc_src     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  localparam int DEPTH   = 256;
  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_result = '0;
  logic [31:0] write_out = '0;
  logic [3:0]  rd_out = '0;
  logic [10:0] sign_out = '0;
  logic [3:0]  branch = '0;
  logic [3:0]  br_cond_out = '0;
  logic [31:0] newPC = '0;
  logic [31:0] data_out;
  logic [3:0]  mem_rd;
  logic        mem_signal;
  logic        pc_src;
  logic [31:0] branch_target;
  logic        stall;

  mem_stage #(.DEPTH(DEPTH), .MEM_LAT(MEM_LAT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_result    (alu_result),
    .write_out     (write_out),
    .rd_out        (rd_out),
    .sign_out      (sign_out),
    .branch        (branch),
    .br_cond_out   (br_cond_out),
    .newPC         (newPC),
    .data_out      (data_out),
    .mem_rd        (mem_rd),
    .mem_signal    (mem_signal),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .stall         (stall)
  );

  always #5 clk = ~clk;

  // One expected entry per clock edge of an instruction
  typedef struct packed {
    logic        stall;
    logic        bubble;
    logic [31:0] data;
    logic [3:0]  rd;
    logic        sig;
    logic        pc;
    logic [31:0] tgt;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  logic [3:0]  ref_flags = '0;

  // Control bits
  localparam logic [10:0] B_RD  = 11'h020;
  localparam logic [10:0] B_WR  = 11'h040;
  localparam logic [10:0] B_M2R = 11'h080;
  localparam logic [10:0] B_BR  = 11'h100;
  localparam logic [10:0] B_RW  = 11'h200;
  localparam logic [10:0] B_SC  = 11'h400;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Condition evaluation straight from the condition-code table
  function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'd1:    return 1'b1;
      4'd2:    return z;
      4'd3:    return !z;
      4'd4:    return n != v;
      4'd5:    return n == v;
      4'd6:    return c;
      4'd7:    return !c;
      default: return 1'b0;
    endcase
  endfunction

  // Apply one instruction, predict its edge-by-edge response, then hold the
  // inputs for as long as the instruction takes.
  task automatic issue(input logic [31:0] alu, input logic [31:0] wdat, input logic [3:0] rd,
                       input logic [10:0] sig, input logic [3:0] flg, input logic [3:0] cc,
                       input logic [31:0] pc);
    exp_t e;
    int idx;
    bit is_mem;
    alu_result = alu; write_out = wdat; rd_out = rd; sign_out = sig;
    branch = flg; br_cond_out = cc; newPC = pc;
    is_mem = sig[5] || sig[6];
    idx = int'((alu / 4) % DEPTH);
    e = '0;
    e.stall = 1'b0;
    e.data = sig[7] ? ref_mem[idx] : alu;
    e.rd = rd;
    e.sig = sig[9];
    e.pc = sig[8] && ref_cond(cc, ref_flags);
    e.tgt = pc;
    if (sig[10]) ref_flags = flg;
    if (sig[6]) ref_mem[idx] = wdat;
    if (is_mem) begin
      exp_t b;
      b = '0;
      b.stall = 1'b1;
      b.bubble = 1'b1;
      for (int k = 0; k < MEM_LAT; k++) sb_q.push_back(b);
    end
    sb_q.push_back(e);
    repeat (is_mem ? MEM_LAT + 1 : 1) @(posedge clk);
    #1;
  endtask

  // Monitor: at each falling edge, check the outputs of the edge that just
  // happened, then the stall level seen by the coming edge.
  exp_t cur;
  bit   cur_valid = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cur_valid = 0;
      end else begin
        if (cur_valid) begin
          chk("mem_signal", 32'(mem_signal), 32'(cur.sig));
          chk("pc_src", 32'(pc_src), 32'(cur.pc));
          if (!cur.bubble) begin
            chk("data_out", data_out, cur.data);
            chk("mem_rd", 32'(mem_rd), 32'(cur.rd));
            chk("branch_target", branch_target, cur.tgt);
          end
          cur_valid = 0;
        end
        if (sb_q.size() > 0) begin
          cur = sb_q.pop_front();
          chk("stall", 32'(stall), 32'(cur.stall));
          cur_valid = 1;
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_data_out"}, data_out, 32'd0);
    chk({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
    chk({tag, "_mem_signal"}, 32'(mem_signal), 32'd0);
    chk({tag, "_pc_src"}, 32'(pc_src), 32'd0);
    chk({tag, "_branch_target"}, branch_target, 32'd0);
  endtask

  initial begin
    logic [10:0] s;
    logic [31:0] a;
    // Reset with a memory op presented: stall must stay low
    sign_out = B_RD;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    sign_out = '0;
    rst_n = 1'b1;

    // Fill the whole RAM so every later load has a known value
    for (int i = 0; i < DEPTH; i++) issue(32'(i * 4), $urandom, 4'd0, B_WR, 4'd0, 4'd0, 32'd0);

    // Plain ALU op
    issue(32'h40, 32'd0, 4'd3, B_RW, 4'd0, 4'd0, 32'd0);
    // Store then load with ignored low address bits
    issue(32'h10, 32'hDEAD_BEEF, 4'd1, B_WR, 4'd0, 4'd0, 32'd0);
    issue(32'h13, 32'd0, 4'd5, B_RD | B_M2R | B_RW, 4'd0, 4'd0, 32'd0);
    // Address wrap modulo DEPTH*4
    issue(32'h400, 32'h1234, 4'd0, B_WR, 4'd0, 4'd0, 32'd0);
    issue(32'h000, 32'd0, 4'd6, B_RD | B_M2R | B_RW, 4'd0, 4'd0, 32'd0);
    // Flags then branch EQ (taken) and NE (not taken)
    issue(32'd0, 32'd0, 4'd0, B_SC, 4'b0100, 4'd0, 32'd0);
    issue(32'd0, 32'd0, 4'd0, B_BR, 4'd0, 4'b0010, 32'h80);
    issue(32'd0, 32'd0, 4'd0, B_SC, 4'b0100, 4'd0, 32'd0);
    issue(32'd0, 32'd0, 4'd0, B_BR, 4'd0, 4'b0011, 32'h80);
    // Same-edge flag update: branch sees old flags, next one sees new
    issue(32'd0, 32'd0, 4'd0, B_SC, 4'b0000, 4'd0, 32'd0);
    issue(32'd0, 32'd0, 4'd0, B_SC | B_BR, 4'b0100, 4'b0010, 32'h84);
    issue(32'd0, 32'd0, 4'd0, B_BR, 4'd0, 4'b0010, 32'h88);

    // Reset in the middle of a store: store must not happen
    issue(32'h20, 32'd0, 4'd0, B_WR, 4'd0, 4'd0, 32'd0);
    alu_result = 32'h20; write_out = 32'hFFFF_FFFF; sign_out = B_WR;
    @(posedge clk);
    #1;
    chk("wait_stall", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    sign_out = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ref_flags = '0;
    issue(32'h20, 32'd0, 4'd7, B_RD | B_M2R | B_RW, 4'd0, 4'd0, 32'd0);

    // Randomized instruction mix
    for (int n = 0; n < 300; n++) begin
      s = 11'($urandom) & 11'h71F;
      if ($urandom_range(0, 3) == 0) s |= B_RD;
      if ($urandom_range(0, 3) == 0) s |= B_WR;
      if (s[5] && !s[6] && $urandom_range(0, 1) == 1) s |= B_M2R;
      a = $urandom;
      issue(a, $urandom, 4'($urandom), s, 4'($urandom), 4'($urandom), $urandom);
    end

    sign_out = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb_q.size()) + 32'(cur_valid), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
